// File: rtl/seq_pkg.sv
// Shared types and RV32I encodings for the instruction sequencer.
// Covers the FSM states, opcode/funct constants, ALU codes and the subset classifier.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    INS_ILLEGAL = 3'd0,
    INS_ADDI    = 3'd1,
    INS_ADD     = 3'd2,
    INS_SUB     = 3'd3,
    INS_BEQ     = 3'd4,
    INS_BNE     = 3'd5
  } instr_kind_t;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Anything outside addi/add/sub/beq/bne falls through to INS_ILLEGAL.
  function automatic instr_kind_t classify(input logic [6:0] opcode,
                                           input logic [2:0] funct3,
                                           input logic [6:0] funct7);
    instr_kind_t kind;
    kind = INS_ILLEGAL;
    case (opcode)
      OP_IMM: if (funct3 == F3_ADD) kind = INS_ADDI;
      OP: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) kind = INS_ADD;
        else if (funct3 == F3_ADD && funct7 == F7_SUB) kind = INS_SUB;
      end
      BRANCH: begin
        if (funct3 == F3_BEQ) kind = INS_BEQ;
        else if (funct3 == F3_BNE) kind = INS_BNE;
      end
      default: kind = INS_ILLEGAL;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory handshake plus the control bundle towards the register-file/ALU datapath.
// The sequencer uses the master view; memory and datapath models use the slave view.
interface instr_sequencer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     imem_req;
  logic [DATA_WIDTH-1:0]    imem_addr;
  logic                     imem_valid;
  logic [DATA_WIDTH-1:0]    imem_instr;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic                     RegWrite;
  logic                     ALUsrc;
  logic [2:0]               ALUctrl;
  logic [DATA_WIDTH-1:0]    ImmOp;
  logic                     eq;

  modport master (
    output imem_req, imem_addr, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp,
    input  imem_valid, imem_instr, eq
  );

  modport slave (
    input  imem_req, imem_addr, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp,
    output imem_valid, imem_instr, eq
  );
endinterface

// File: rtl/imm_ext.sv
// Sign-extends the I-type or B-type immediate of an RV32I word.
// Takes only the fields it needs: instr[31:20] and instr[11:7].
module imm_ext #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [11:0]           i_field,
  input  logic [4:0]            rd_field,
  input  logic                  is_branch,
  output logic [DATA_WIDTH-1:0] imm
);
  logic [12:0] b_imm;

  assign b_imm = {i_field[11], rd_field[0], i_field[10:5], rd_field[4:1], 1'b0};

  always_comb begin
    if (is_branch) imm = {{(DATA_WIDTH-13){b_imm[12]}}, b_imm};
    else           imm = {{(DATA_WIDTH-12){i_field[11]}}, i_field};
  end
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for addi/add/sub/beq/bne.
// Define ILLEGAL_HALT_EN to stop in HALT on an illegal word; otherwise illegal words execute as NOPs.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_sequencer_if.master     bus,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  halt
);
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           instr_q, instr_d;
  instr_kind_t           kind;
  logic [DATA_WIDTH-1:0] imm;
  logic                  req;
  logic                  reg_write;
  logic                  alu_src;
  logic [2:0]            alu_ctrl;
  logic                  taken;

  // Register fields and immediate are decoded straight from the latched word,
  // so they change only when a new word is latched and hold until the next one.
  assign kind = classify(instr_q[6:0], instr_q[14:12], instr_q[31:25]);

  imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm_ext (
    .i_field  (instr_q[31:20]),
    .rd_field (instr_q[11:7]),
    .is_branch(instr_q[6:0] == BRANCH),
    .imm      (imm)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    req       = 1'b0;
    reg_write = 1'b0;
    alu_src   = 1'b0;
    alu_ctrl  = ALU_ADD;
    taken     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req = 1'b1;
        if (bus.imem_valid) begin
          instr_d = bus.imem_instr[31:0];
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
`ifdef ILLEGAL_HALT_EN
        if (kind == INS_ILLEGAL) state_d = ST_HALT;
`endif
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (kind)
          INS_ADDI: begin alu_src = 1'b1; reg_write = 1'b1; end
          INS_ADD:  reg_write = 1'b1;
          INS_SUB:  begin alu_ctrl = ALU_SUB; reg_write = 1'b1; end
          INS_BEQ:  begin alu_ctrl = ALU_SUB; taken = bus.eq; end
          INS_BNE:  begin alu_ctrl = ALU_SUB; taken = !bus.eq; end
          default:  ;
        endcase
        if (instr_q[11:7] == 5'd0) reg_write = 1'b0;
        pc_d = taken ? (pc_q + imm) : (pc_q + DATA_WIDTH'(4));
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // The request is masked by reset so a held reset never looks like a fetch.
  assign bus.imem_req  = req & rst_n;
  assign bus.imem_addr = pc_q;
  assign bus.rs1       = ADDRESS_WIDTH'(instr_q[19:15]);
  assign bus.rs2       = ADDRESS_WIDTH'(instr_q[24:20]);
  assign bus.rd        = ADDRESS_WIDTH'(instr_q[11:7]);
  assign bus.ImmOp     = imm;
  assign bus.RegWrite  = reg_write;
  assign bus.ALUsrc    = alu_src;
  assign bus.ALUctrl   = alu_ctrl;
  assign pc            = pc_q;

`ifdef ILLEGAL_HALT_EN
  assign halt = (state_q == ST_HALT);
`else
  assign halt = 1'b0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: an instruction-level model predicts every output each cycle.
// Compile with ILLEGAL_HALT_EN defined to exercise the halting variant.
module tb_instr_sequencer;
  localparam int          DW       = 32;
  localparam int          AW       = 5;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef ILLEGAL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam int K_ILL = 0, K_ADDI = 1, K_ADD = 2, K_SUB = 3, K_BEQ = 4, K_BNE = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        halt;

  instr_sequencer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  instr_sequencer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .pc   (pc),
    .halt (halt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: architectural PC, last decoded fields, expected strobes this cycle.
  logic [31:0] m_pc, m_rs1, m_rs2, m_rd, m_imm;
  logic [31:0] exp_req, exp_rw, exp_src, exp_ctrl, exp_halt;
  logic [31:0] cap_rw, cap_src, cap_ctrl;
  int          chk_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [31:0] w);
    if (w[6:0] == 7'h13 && w[14:12] == 3'd0) return K_ADDI;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00) return K_ADD;
    if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h20) return K_SUB;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd0) return K_BEQ;
    if (w[6:0] == 7'h63 && w[14:12] == 3'd1) return K_BNE;
    return K_ILL;
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] w);
    if (w[6:0] == 7'h63) return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    return {{20{w[31]}}, w[31:20]};
  endfunction

  always @(negedge clk) begin
    if (chk_mode != 0) chk("imem_req", 32'(bus.imem_req), exp_req);
    if (chk_mode == 2) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("rs1", 32'(bus.rs1), m_rs1);
      chk("rs2", 32'(bus.rs2), m_rs2);
      chk("rd", 32'(bus.rd), m_rd);
      chk("ImmOp", bus.ImmOp, m_imm);
      chk("RegWrite", 32'(bus.RegWrite), exp_rw);
      chk("ALUsrc", 32'(bus.ALUsrc), exp_src);
      chk("ALUctrl", 32'(bus.ALUctrl), exp_ctrl);
      chk("halt", 32'(halt), exp_halt);
    end
  end

  task automatic set_idle();
    exp_req = 0; exp_rw = 0; exp_src = 0; exp_ctrl = 0; exp_halt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.imem_valid = 1'b0;
    bus.eq = 1'b0;
    set_idle();
    chk_mode = 1;
    tick();
    m_pc = RESET_PC; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0;
    chk_mode = 2;
    for (int i = 1; i < n; i++) tick();
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] w, input int wait_n, input bit eqv, input bit rst_in_exec);
    int  k;
    bit  taken;
    logic [31:0] imm;
    k = classify(w);
    imm = imm_of(w);
    for (int c = 0; c <= wait_n; c++) begin
      set_idle();
      exp_req = 1;
      chk_mode = 2;
      bus.imem_valid = (c == wait_n);
      bus.imem_instr = (c == wait_n) ? w : $urandom;
      bus.eq = 1'($urandom_range(1, 0));
      tick();
    end
    // DECODE: a stray valid here must be ignored
    m_rs1 = 32'(w[19:15]); m_rs2 = 32'(w[24:20]); m_rd = 32'(w[11:7]); m_imm = imm;
    set_idle();
    bus.imem_valid = 1'b1;
    bus.imem_instr = $urandom;
    tick();
    if (k == K_ILL && HALT_EN) begin
      set_idle();
      exp_halt = 1;
      for (int i = 0; i < 4; i++) tick();
      $display("instr %h pc %h -> halted", w, m_pc);
      return;
    end
    if (rst_in_exec) begin
      do_reset(2);
      $display("instr %h -> reset during EXEC", w);
      return;
    end
    set_idle();
    bus.eq = eqv;
    case (k)
      K_ADDI: begin exp_rw = 1; exp_src = 1; end
      K_ADD:  exp_rw = 1;
      K_SUB:  begin exp_rw = 1; exp_ctrl = 1; end
      K_BEQ, K_BNE: exp_ctrl = 1;
      default: ;
    endcase
    if (m_rd == 0) exp_rw = 0;
    taken = (k == K_BEQ && eqv) || (k == K_BNE && !eqv);
    #1;
    cap_rw = 32'(bus.RegWrite); cap_src = 32'(bus.ALUsrc); cap_ctrl = 32'(bus.ALUctrl);
    @(posedge clk);
    #1;
    m_pc = taken ? m_pc + imm : m_pc + 32'd4;
    bus.imem_valid = 1'b0;
    $display("instr %h wait %0d eq %0d -> next pc %h", w, wait_n, eqv, m_pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_instr = '0;
    bus.eq = 1'b0;
    set_idle();
    m_pc = RESET_PC; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0;
    cap_rw = 0; cap_src = 0; cap_ctrl = 0;

    do_reset(2);
    chk("reset_pc", pc, 32'h0);
    chk("reset_regwrite", 32'(bus.RegWrite), 32'd0);

    run_instr(32'h00500513, 0, 1'b0, 1'b0);   // addi x10,x0,5
    chk("addi_pc", pc, 32'd4);
    chk("addi_rd", 32'(bus.rd), 32'd10);
    chk("addi_rs1", 32'(bus.rs1), 32'd0);
    chk("addi_imm", bus.ImmOp, 32'd5);
    chk("addi_regwrite", cap_rw, 32'd1);
    chk("addi_alusrc", cap_src, 32'd1);
    chk("addi_aluctrl", cap_ctrl, 32'd0);

    run_instr(32'h002081B3, 3, 1'b0, 1'b0);   // add x3,x1,x2, delayed valid
    chk("add_pc", pc, 32'd8);

    run_instr(32'hFE051EE3, 0, 1'b0, 1'b0);   // bne x10,x0,-4, eq=0 -> taken
    chk("bne_taken_pc", pc, 32'd4);
    chk("bne_imm", bus.ImmOp, 32'hFFFF_FFFC);
    chk("bne_regwrite", cap_rw, 32'd0);

    run_instr(32'h407302B3, 0, 1'b0, 1'b0);   // sub x5,x6,x7
    chk("sub_aluctrl", cap_ctrl, 32'd1);
    chk("sub_pc", pc, 32'd8);

    run_instr(32'hFE051EE3, 0, 1'b1, 1'b0);   // bne, eq=1 -> not taken
    chk("bne_not_taken_pc", pc, 32'd12);
    chk("bne_nt_regwrite", cap_rw, 32'd0);

    run_instr(32'h00000463, 0, 1'b1, 1'b0);   // beq x0,x0,+8 taken
    chk("beq_taken_pc", pc, 32'd20);
    run_instr(32'h00000463, 1, 1'b0, 1'b0);   // beq not taken
    chk("beq_not_taken_pc", pc, 32'd24);

    run_instr(32'h00100013, 0, 1'b0, 1'b0);   // addi x0,x0,1
    chk("addi_x0_regwrite", cap_rw, 32'd0);
    chk("addi_x0_pc", pc, 32'd28);

    run_instr(32'hFFFFFFFF, 0, 1'b0, 1'b0);   // illegal
`ifdef ILLEGAL_HALT_EN
    chk("halt_pc_frozen", pc, 32'd28);
    chk("halt_flag", 32'(halt), 32'd1);
`else
    chk("nop_pc", pc, 32'd32);
    chk("nop_regwrite", cap_rw, 32'd0);
`endif

    do_reset(2);
    chk("rereset_pc", pc, 32'h0);
    chk("rereset_halt", 32'(halt), 32'd0);

    run_instr(32'hFE000EE3, 0, 1'b1, 1'b0);   // beq x0,x0,-4 from 0 wraps
    chk("wrap_back_pc", pc, 32'hFFFF_FFFC);
    run_instr(32'h00500513, 2, 1'b0, 1'b0);   // +4 wraps to 0
    chk("wrap_fwd_pc", pc, 32'h0);

    run_instr(32'h002081B3, 0, 1'b0, 1'b1);   // reset asserted during EXEC
    chk("exec_reset_pc", pc, 32'h0);
    chk("exec_reset_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("exec_reset_rd", 32'(bus.rd), 32'd0);

    run_instr(32'h00500513, 0, 1'b0, 1'b0);
    chk("post_reset_pc", pc, 32'd4);

    chk_mode = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
